// File: rtl/modbus_rtu_tx.sv
// MODBUS RTU response transmitter: appends CRC-16/MODBUS and sends 11-bit even-parity UART characters.
// Latency: uart_tx falls one cycle after a byte handshake; the CRC follows the last payload byte back to back.
// Backpressure: tx_ready is high only in IDLE/WAIT_BYTE; the gap timer aborts a frame whose next byte is late.
`timescale 1ns/1ps
module modbus_rtu_tx #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int SILENCE_BITS = 39,
  parameter int GAP_BITS     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort
);

  localparam int SIL_CYC = SILENCE_BITS * CLKS_PER_BIT;
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int TMR_W   = $clog2((SIL_CYC > GAP_CYC) ? SIL_CYC : GAP_CYC);
  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);

  localparam logic [TMR_W-1:0]  SIL_END   = TMR_W'(SIL_CYC - 1);
  localparam logic [TMR_W-1:0]  GAP_END   = TMR_W'(GAP_CYC - 1);
  localparam logic [BAUD_W-1:0] BIT_END   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] CRC_STEPS = BAUD_W'(8);

  typedef enum logic [2:0] {SILENCE, IDLE, SHIFT, WAIT_BYTE, CRC_LO, CRC_HI} state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [3:0]         bit_cnt;
  logic [9:0]         sh;          // {stop, parity, data} still to be sent after the start bit
  logic [15:0]        crc;
  logic               last_q;
  logic               tx_act, bit_end, char_end;
  logic               load, take, done_set, abort_set;
  logic [7:0]         load_byte;

  // One CRC-16/MODBUS bit iteration (reflected polynomial 0xA001).
  function automatic logic [15:0] crc_step(input logic [15:0] c);
    return c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
  endfunction

  assign tx_act   = (state == SHIFT) || (state == CRC_LO) || (state == CRC_HI);
  assign bit_end  = (baud_cnt == BIT_END);
  assign char_end = tx_act && bit_end && (bit_cnt == 4'd10);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SILENCE;
    else        state <= state_nxt;
  end

  // Next-state decode plus handshake, character-load and pulse requests.
  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    load      = 1'b0;
    load_byte = tx_data;
    take      = 1'b0;
    done_set  = 1'b0;
    abort_set = 1'b0;
    case (state)
      SILENCE: if (tmr == SIL_END) state_nxt = IDLE;
      IDLE, WAIT_BYTE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          take      = 1'b1;
          load      = 1'b1;
          state_nxt = SHIFT;
        end else if ((state == WAIT_BYTE) && (tmr == GAP_END)) begin
          abort_set = 1'b1;
          state_nxt = SILENCE;
        end
      end
      SHIFT: begin
        if (char_end) begin
          if (last_q) begin
            load      = 1'b1;
            load_byte = crc[7:0];
            state_nxt = CRC_LO;
          end else begin
            state_nxt = WAIT_BYTE;
          end
        end
      end
      CRC_LO: begin
        if (char_end) begin
          load      = 1'b1;
          load_byte = crc[15:8];
          state_nxt = CRC_HI;
        end
      end
      CRC_HI: begin
        if (char_end) begin
          done_set  = 1'b1;
          state_nxt = SILENCE;
        end
      end
      default: state_nxt = SILENCE;
    endcase
  end

  // Silence / inter-character gap timer, restarted on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        tmr <= '0;
    else if (state_nxt != state)                       tmr <= '0;
    else if ((state == SILENCE) || (state == WAIT_BYTE)) tmr <= tmr + 1'b1;
  end

  // Character serializer; counters restart on every load so characters never drift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '1;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (load) begin
      sh       <= {1'b1, ^load_byte, load_byte};
      uart_tx  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (tx_act) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt != 4'd10) begin
          bit_cnt <= bit_cnt + 4'd1;
          uart_tx <= sh[0];
          sh      <= {1'b1, sh[9:1]};
        end else begin
          uart_tx <= 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  // CRC: fold byte on acceptance, then one iteration per clock inside the start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                 crc <= 16'hFFFF;
    else if ((state_nxt == SILENCE) && (state != SILENCE))      crc <= 16'hFFFF;
    else if (take)                                              crc <= crc ^ {8'h00, tx_data};
    else if ((state == SHIFT) && (bit_cnt == 4'd0) && (baud_cnt < CRC_STEPS))
                                                                crc <= crc_step(crc);
  end

  // Frame bookkeeping: last flag, busy window and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      if (take) last_q <= tx_last;
      if (take)                                          busy <= 1'b1;
      else if ((state == SILENCE) && (state_nxt == IDLE)) busy <= 1'b0;
      frame_done  <= done_set;
      frame_abort <= abort_set;
    end
  end

endmodule

// File: tb/tb_modbus_rtu_tx.sv
`timescale 1ns/1ps
module tb_modbus_rtu_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, uart_tx, busy, frame_done, frame_abort;

  int total = 0;
  int bad = 0;
  int rx_err = 0;
  logic [7:0] rx_q[$];

  modbus_rtu_tx #(.CLKS_PER_BIT(16), .SILENCE_BITS(39), .GAP_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .busy(busy),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // UART receiver: mid-bit sampling, drops any character overlapped by reset.
  initial begin : uart_rx
    logic [7:0] d;
    logic st, p, s, abandon;
    forever begin
      @(negedge clk);
      if (rst_n && (uart_tx === 1'b0)) begin
        abandon = 1'b0;
        d = 8'h00;
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (!rst_n) abandon = 1'b1; end
        st = uart_tx;
        for (int b = 0; b < 8; b++) begin
          for (int k = 0; k < 16; k++) begin @(negedge clk); if (!rst_n) abandon = 1'b1; end
          d[b] = uart_tx;
        end
        for (int k = 0; k < 16; k++) begin @(negedge clk); if (!rst_n) abandon = 1'b1; end
        p = uart_tx;
        for (int k = 0; k < 16; k++) begin @(negedge clk); if (!rst_n) abandon = 1'b1; end
        s = uart_tx;
        if (!abandon) begin
          if ((st !== 1'b0) || (p !== ^d) || (s !== 1'b1)) rx_err++;
          rx_q.push_back(d);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, want finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input string tag, input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    chk({tag, "_hs"}, 64'(tx_ready), 64'(1));
    @(posedge clk);
    #1 tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic send_frame(input string tag, input logic [63:0] f, input int n);
    for (int i = 0; i < n; i++)
      send_byte(tag, f[8*(n-1-i) +: 8], (i == n - 1));
  endtask

  task automatic check_rx(input string tag, input int base, input int n, input logic [63:0] exp);
    logic [63:0] got;
    got = '0;
    chk({tag, "_cnt"}, 64'(rx_q.size() - base), 64'(n));
    for (int i = 0; i < n; i++)
      got = {got[55:0], (base + i < rx_q.size()) ? rx_q[base + i] : 8'h00};
    chk({tag, "_bytes"}, got, exp);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!frame_done && n < 3000) begin @(negedge clk); n++; end
    chk(tag, 64'(frame_done), 64'(1));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    chk(tag, 64'(busy), 64'(0));
  endtask

  // Release reset just after an edge and time the silence until tx_ready rises.
  task automatic release_and_measure(input string tag);
    int cnt;
    logic low;
    cnt = 0; low = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    while (!tx_ready && cnt < 2000) begin
      if (!uart_tx) low = 1'b1;
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_len"}, 64'(cnt), 64'(624));
    chk({tag, "_line"}, 64'(low), 64'(0));
  endtask

  initial begin : main
    int base, n, cnt, pulses;
    logic [10:0] eb;
    logic [15:0] ob;

    // 1: reset values and initial silence
    repeat (3) @(negedge clk);
    chk("rst_line", 64'(uart_tx), 64'(1));
    chk("rst_rdy", 64'(tx_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_abort", 64'(frame_abort), 64'(0));
    release_and_measure("t1_sil");

    // 2: six-byte request, CRC D5 CA, done pulse, busy tail
    base = rx_q.size();
    send_byte("t2", 8'h01, 1'b0);
    chk("t2_busy", 64'(busy), 64'(1));
    chk("t2_rdy_shift", 64'(tx_ready), 64'(0));
    send_frame("t2", 64'h0300010001, 5);
    wait_done("t2_done");
    cnt = 0; pulses = 0;
    while (busy && cnt < 2000) begin
      if (frame_done) pulses++;
      if (tx_ready) pulses += 100;
      cnt++;
      @(negedge clk);
    end
    chk("t2_busy_tail", 64'(cnt), 64'(624));
    chk("t2_done_pulses", 64'(pulses), 64'(1));
    check_rx("t2_rx", base, 8, 64'h010300010001D5CA);

    // 3: alternate request, CRC 84 0A, clean framing
    base = rx_q.size();
    send_frame("t3", 64'h010300000001, 6);
    wait_done("t3_done");
    check_rx("t3_rx", base, 8, 64'h010300000001840A);
    chk("t3_rx_err", 64'(rx_err), 64'(0));
    wait_idle("t3_idle");

    // 4: bit-level waveform of 0x01 as a single-byte frame
    base = rx_q.size();
    send_byte("t4a", 8'h01, 1'b1);
    eb = {1'b1, 1'b1, 8'h01, 1'b0};
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 16; k++) begin @(negedge clk); ob[k] = uart_tx; end
      chk($sformatf("t4_b01_bit%0d", i), 64'(ob), 64'({16{eb[i]}}));
    end
    wait_done("t4a_done");
    check_rx("t4a_rx", base, 3, 64'h017E80);
    wait_idle("t4a_idle");
    send_byte("t4b", 8'h03, 1'b1);
    repeat (144) @(negedge clk);
    for (int k = 0; k < 16; k++) begin @(negedge clk); ob[k] = uart_tx; end
    chk("t4_b03_parity", 64'(ob), 64'(0));
    wait_done("t4b_done");
    wait_idle("t4b_idle");

    // 5: inter-character gap timeout
    base = rx_q.size();
    send_byte("t5", 8'h01, 1'b0);
    send_byte("t5", 8'h03, 1'b0);
    n = 0;
    @(negedge clk);
    while (!frame_abort && n < 1000) begin n++; @(negedge clk); end
    chk("t5_abort_time", 64'(n), 64'(432));
    cnt = 0; pulses = 0;
    while (!tx_ready && cnt < 2000) begin
      if (frame_abort) pulses++;
      if (frame_done) pulses += 100;
      cnt++;
      @(negedge clk);
    end
    chk("t5_abort_pulses", 64'(pulses), 64'(1));
    chk("t5_sil_len", 64'(cnt), 64'(624));
    check_rx("t5_rx", base, 2, 64'h0103);

    // 6: reset in the middle of the second character, then a clean frame
    send_byte("t6", 8'h01, 1'b0);
    send_byte("t6", 8'h03, 1'b0);
    repeat (56) @(negedge clk);
    chk("t6_pre_line", 64'(uart_tx), 64'(0));
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_line", 64'(uart_tx), 64'(1));
    chk("t6_rst_rdy", 64'(tx_ready), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    release_and_measure("t6_sil");
    base = rx_q.size();
    send_frame("t6b", 64'h010300000001, 6);
    wait_done("t6_done");
    check_rx("t6_rx", base, 8, 64'h010300000001840A);
    chk("t6_rx_err", 64'(rx_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modbus_rtu_tx.md
Name: modbus_rtu_tx

Overview:
MODBUS RTU response transmitter. It sits between the MODBUS FSM (clk_sys domain) and the uart_tx pin, and takes response bytes on a valid/ready byte stream with a last flag. It computes CRC-16/MODBUS on the fly and appends it, low byte first. It serializes each character as 11-bit UART (start, 8 data LSB-first, even parity, stop) and enforces RTU inter-frame silence and the maximum inter-character gap.

Parameters:
CLKS_PER_BIT, 2604, clk cycles per UART bit (50 MHz / 19200). Must be >= 16.
SILENCE_BITS, 39, idle bit times enforced after reset and after every frame (3.5 chars x 11 bits, rounded up).
GAP_BITS, 16, max idle bit times between characters inside a frame (1.5 chars); reaching it aborts the frame.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  8  response byte from FSM
tx_valid  input  1  tx_data valid
tx_last  input  1  qualifies tx_data as final payload byte of frame
tx_ready  output  1  block accepts byte this cycle
uart_tx  output  1  serial line, idle high
busy  output  1  high from first byte accepted until post-frame silence ends
frame_done  output  1  one-cycle pulse when stop bit of CRC high byte completes
frame_abort  output  1  one-cycle pulse on inter-character gap timeout

Behaviour:
- Reset (async, rst_n=0): uart_tx=1, tx_ready=0, busy=0, frame_done=0, frame_abort=0, CRC=16'hFFFF, state=SILENCE. Deassertion mid-character: line returns high immediately; full SILENCE_BITS silence precedes first ready.
- States:
  - SILENCE: counts SILENCE_BITS*CLKS_PER_BIT cycles with uart_tx=1, then goes to IDLE.
  - IDLE: tx_ready=1. tx_valid&&tx_ready loads the byte and goes to SHIFT; busy=1.
  - SHIFT: emits start(0), d[0]..d[7], parity=^d, stop(1), each bit exactly CLKS_PER_BIT cycles. uart_tx falls the cycle after acceptance.
  - After a payload byte: tx_last=1 goes to CRC_LO; otherwise goes to WAIT_BYTE.
  - WAIT_BYTE: tx_ready=1, gap counter runs. Byte accepted goes to SHIFT with no extra idle cycle. Counter reaching GAP_BITS*CLKS_PER_BIT gives frame_abort pulse, CRC not sent, goes to SILENCE.
  - CRC_LO / CRC_HI: shift CRC[7:0] then CRC[15:8] as normal characters, back to back. tx_ready=0.
  - End of CRC_HI stop bit: frame_done pulse, CRC reinit to FFFF, goes to SILENCE; busy drops on SILENCE exit.
- tx_ready is 0 in SHIFT, CRC_LO, CRC_HI and SILENCE; tx_valid is ignored there. Upstream holds data until handshake.
- CRC: init FFFF. Per payload byte: crc ^= byte, then 8 iterations of crc = crc[0] ? (crc>>1)^16'hA001 : crc>>1. One iteration per clk during the start bit, done before first data bit (hence CLKS_PER_BIT>=16). CRC bytes are not folded into CRC.
- Bit counter and baud counter restart on each character load; no drift across characters.
- Single-byte frame (first byte with tx_last=1) is legal: 3 characters on the line.
- tx_last on a WAIT_BYTE byte behaves identically to the IDLE case.

Test Plan:
1. CLKS_PER_BIT=16. Reset, then check uart_tx=1, tx_ready=0 for exactly 39*16 cycles, then tx_ready=1.
2. Send 01 03 00 01 00 01 (last on 6th) -> line carries 8 chars ending D5 CA; frame_done one pulse after final stop; busy low 39 bit times later.
3. Send 01 03 00 00 00 01 -> appended CRC bytes 84 then 0A. Bench UART decoder reports zero parity/stop errors.
4. Byte 8'h01 -> line sequence 0,1,0,0,0,0,0,0,0,1(parity),1(stop), each bit 16 cycles. Byte 8'h03 -> parity bit 0.
5. Send 01 03 then withhold tx_valid -> frame_abort pulse 16*16 cycles after 2nd stop bit; no CRC characters; tx_ready held 0 for 39 bit times.
6. Assert rst_n=0 mid data bit of 2nd byte -> uart_tx=1 same cycle. After release, the next frame 01 03 00 00 00 01 still yields CRC 84 0A.
